// File: rtl/fetch_sequencer_pkg.sv
// Shared state encoding, EBREAK opcode and default watchdog sizing for the fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [31:0] EBREAK_INSTR    = 32'h0010_0073;
  localparam int          DEF_ACK_TIMEOUT = 16;
  localparam int          DEF_TW_W        = 5;

endpackage

// File: rtl/fetch_sequencer_ack_watchdog.sv
// imem acknowledge watchdog: counts REQ cycles and flags the last cycle allowed before timeout.
module fetch_ack_watchdog
  import fetch_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int TW_W        = DEF_TW_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TW_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign expire = (count == TW_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: imem request, issue, execute wait and IFU PC load, with ack watchdog and retire count.
// Optional EBREAK halt detection is enabled by defining FETCH_HALT_DETECT_EN.
//
// state    | meaning
// IDLE     | waiting for start_FS
// REQ      | imem_req_FS high, waiting for imem_ack_FS (watchdog running)
// ISSUE    | instruction latched, instr_valid_FS pulsed
// EXEC     | waiting for exec_done_FS, then load PC
// HALT     | EBREAK seen (halt detect build only), stuck until reset
// ERROR    | imem ack timeout, stuck until reset
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int TW_W        = DEF_TW_W,
  parameter int CNT_W       = 32
) (
  input  logic             clk_FS,
  input  logic             areset_FS,
  input  logic             start_FS,
  output logic             imem_req_FS,
  input  logic             imem_ack_FS,
  input  logic [31:0]      imem_rdata_FS,
  output logic [31:0]      instr_FS,
  output logic             instr_valid_FS,
  input  logic             exec_done_FS,
  input  logic             branch_taken_FS,
  output logic             load_FS,
  output logic             PCSrc_FS,
  output logic             halt_FS,
  output logic             err_FS,
  output logic [CNT_W-1:0] ret_cnt_FS
);

  state_t state;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expire;

  assign wd_en  = (state == ST_REQ);
  assign wd_clr = ((state == ST_IDLE) && start_FS) || ((state == ST_EXEC) && exec_done_FS);

  fetch_ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TW_W       (TW_W)
  ) u_watchdog (
    .clk   (clk_FS),
    .rst   (areset_FS),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  // Combinational so the IFU updates its PC on the same edge that retires the instruction.
  assign load_FS  = (state == ST_EXEC) && exec_done_FS;
  assign PCSrc_FS = load_FS && branch_taken_FS;

`ifndef FETCH_HALT_DETECT_EN
  assign halt_FS = 1'b0;
`endif

  always_ff @(posedge clk_FS or posedge areset_FS) begin
    if (areset_FS) begin
      state          <= ST_IDLE;
      imem_req_FS    <= 1'b0;
      instr_valid_FS <= 1'b0;
      err_FS         <= 1'b0;
      instr_FS       <= '0;
      ret_cnt_FS     <= '0;
`ifdef FETCH_HALT_DETECT_EN
      halt_FS        <= 1'b0;
`endif
    end else begin
      instr_valid_FS <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_FS) begin
            state       <= ST_REQ;
            imem_req_FS <= 1'b1;
          end
        end
        ST_REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (imem_ack_FS) begin
            instr_FS       <= imem_rdata_FS;
            state          <= ST_ISSUE;
            imem_req_FS    <= 1'b0;
            instr_valid_FS <= 1'b1;
          end else if (wd_expire) begin
            state       <= ST_ERROR;
            imem_req_FS <= 1'b0;
            err_FS      <= 1'b1;
          end
        end
        ST_ISSUE: begin
`ifdef FETCH_HALT_DETECT_EN
          if (instr_FS == EBREAK_INSTR) begin
            state   <= ST_HALT;
            halt_FS <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
`else
          state <= ST_EXEC;
`endif
        end
        ST_EXEC: begin
          if (exec_done_FS) begin
            ret_cnt_FS  <= ret_cnt_FS + CNT_W'(1);
            state       <= ST_REQ;
            imem_req_FS <= 1'b1;
          end
        end
        ST_HALT, ST_ERROR: begin
        end
        default: begin
          state       <= ST_IDLE;
          imem_req_FS <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle reference model plus directed scenarios.
module tb_fetch_sequencer;

  localparam int ACK_TO = 16;
  localparam int TW     = 5;
  localparam int CW     = 32;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk_FS = 1'b0;
  logic          areset_FS;
  logic          start_FS;
  logic          imem_req_FS;
  logic          imem_ack_FS;
  logic [31:0]   imem_rdata_FS;
  logic [31:0]   instr_FS;
  logic          instr_valid_FS;
  logic          exec_done_FS;
  logic          branch_taken_FS;
  logic          load_FS;
  logic          PCSrc_FS;
  logic          halt_FS;
  logic          err_FS;
  logic [CW-1:0] ret_cnt_FS;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_FS = ~clk_FS;

  fetch_sequencer #(
    .ACK_TIMEOUT(ACK_TO),
    .TW_W       (TW),
    .CNT_W      (CW)
  ) dut (
    .clk_FS         (clk_FS),
    .areset_FS      (areset_FS),
    .start_FS       (start_FS),
    .imem_req_FS    (imem_req_FS),
    .imem_ack_FS    (imem_ack_FS),
    .imem_rdata_FS  (imem_rdata_FS),
    .instr_FS       (instr_FS),
    .instr_valid_FS (instr_valid_FS),
    .exec_done_FS   (exec_done_FS),
    .branch_taken_FS(branch_taken_FS),
    .load_FS        (load_FS),
    .PCSrc_FS       (PCSrc_FS),
    .halt_FS        (halt_FS),
    .err_FS         (err_FS),
    .ret_cnt_FS     (ret_cnt_FS)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: where the instruction flow is, described by running/halted/errored
  // flags, a pipeline phase (0 fetch, 1 issue, 2 execute) and cycles spent waiting for ack.
  bit          m_run, m_halt, m_err;
  int          m_phase, m_wait;
  logic [31:0] m_instr;
  logic [CW-1:0] m_cnt;

  initial begin
    logic e_req, e_valid, e_load, e_pc;
    forever begin
      @(negedge clk_FS);
      #1;
      if (areset_FS === 1'b1) begin
        m_run = 0; m_halt = 0; m_err = 0; m_phase = 0; m_wait = 0;
        m_instr = '0; m_cnt = '0;
      end
      e_req   = m_run && (m_phase == 0);
      e_valid = m_run && (m_phase == 1);
      e_load  = m_run && (m_phase == 2) && exec_done_FS;
      e_pc    = e_load && branch_taken_FS;
      chk("model_req",   imem_req_FS,    e_req);
      chk("model_valid", instr_valid_FS, e_valid);
      chk("model_load",  load_FS,        e_load);
      chk("model_pcsrc", PCSrc_FS,       e_pc);
      chk("model_halt",  halt_FS,        m_halt);
      chk("model_err",   err_FS,         m_err);
      chk("model_instr", instr_FS,       m_instr);
      chk("model_cnt",   ret_cnt_FS,     m_cnt);
      if (areset_FS !== 1'b1) begin
        if (!m_run && !m_halt && !m_err) begin
          if (start_FS) begin
            m_run = 1; m_phase = 0; m_wait = 0;
          end
        end else if (m_run) begin
          if (m_phase == 0) begin
            if (imem_ack_FS) begin
              m_instr = imem_rdata_FS;
              m_phase = 1;
            end else if (m_wait + 1 >= ACK_TO) begin
              m_run = 0; m_err = 1;
            end else begin
              m_wait++;
            end
          end else if (m_phase == 1) begin
            if (HALT_EN && m_instr == EBREAK) begin
              m_run = 0; m_halt = 1;
            end else begin
              m_phase = 2;
            end
          end else begin
            if (exec_done_FS) begin
              m_cnt = m_cnt + 1'b1;
              m_phase = 0;
              m_wait = 0;
            end
          end
        end
      end
    end
  end

  task automatic step(input logic st, input logic ak, input logic [31:0] rd,
                      input logic dn, input logic br);
    @(negedge clk_FS);
    start_FS        = st;
    imem_ack_FS     = ak;
    imem_rdata_FS   = rd;
    exec_done_FS    = dn;
    branch_taken_FS = br;
    #2;
  endtask

  task automatic pulse_reset();
    areset_FS = 1'b1;
    @(negedge clk_FS);
    #3 areset_FS = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int loads, valids, pcs, reqs;
    areset_FS = 1'b1;
    start_FS = 0; imem_ack_FS = 0; imem_rdata_FS = '0; exec_done_FS = 0; branch_taken_FS = 0;
    repeat (2) step(0, 0, 32'h0, 0, 0);
    areset_FS = 1'b0;
    step(0, 0, 32'h0, 0, 0);
    chk("rst_req", imem_req_FS, 0);
    chk("rst_valid", instr_valid_FS, 0);
    chk("rst_err", err_FS, 0);
    chk("rst_instr", instr_FS, 0);
    chk("rst_cnt", ret_cnt_FS, 0);

    // Back-to-back instructions at best-case throughput
    loads = 0; valids = 0; pcs = 0;
    for (int i = 0; i < 13; i++) begin
      step(i == 0, 1, 32'h1000_0000 + i, 1, 0);
      loads += load_FS; valids += instr_valid_FS; pcs += PCSrc_FS;
    end
    chk("t1_loads", loads, 4);
    chk("t1_valids", valids, 4);
    chk("t1_pcsrc", pcs, 0);

    // Ack delayed by 5 cycles
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, i == 5, (i == 5) ? 32'h00A0_0093 : 32'hDEAD_0000 + i, 0, 0);
      reqs += imem_req_FS;
    end
    chk("t2_req_cycles", reqs, 6);
    chk("t2_cnt", ret_cnt_FS, 4);
    step(0, 0, 32'h0, 0, 0);
    chk("t2_valid", instr_valid_FS, 1);
    chk("t2_instr", instr_FS, 32'h00A0_0093);
    chk("t2_err", err_FS, 0);

    // Long execute, taken branch
    loads = 0; pcs = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 32'h0, 0, 1);
      loads += load_FS; pcs += PCSrc_FS;
    end
    step(0, 0, 32'h0, 1, 1);
    chk("t3_load", load_FS, 1);
    chk("t3_pcsrc", PCSrc_FS, 1);
    chk("t3_req_same", imem_req_FS, 0);
    loads += load_FS; pcs += PCSrc_FS;
    chk("t3_loads", loads, 1);
    chk("t3_pcs", pcs, 1);
    step(0, 0, 32'h0, 0, 0);
    chk("t3_req_next", imem_req_FS, 1);
    chk("t3_cnt", ret_cnt_FS, 5);

    // Asynchronous reset in the middle of EXEC
    step(0, 1, 32'h0000_0013, 0, 0);
    step(0, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 1, 1);
    chk("t5_load_before", load_FS, 1);
    #1 areset_FS = 1'b1;
    #1;
    chk("t5_load", load_FS, 0);
    chk("t5_pcsrc", PCSrc_FS, 0);
    chk("t5_req", imem_req_FS, 0);
    chk("t5_cnt", ret_cnt_FS, 0);
    chk("t5_instr", instr_FS, 0);
    @(negedge clk_FS);
    #3 areset_FS = 1'b0;

    // Resume, then EBREAK
    step(1, 1, 32'h0000_0013, 1, 0);
    step(0, 1, 32'h0000_0013, 1, 0);
    step(0, 1, EBREAK, 1, 0);
    step(0, 1, EBREAK, 1, 0);
    chk("t5_resume_load", load_FS, 1);
    step(0, 1, EBREAK, 1, 0);
    chk("t5_resume_cnt", ret_cnt_FS, 1);
    step(0, 0, 32'h0, 1, 0);
    chk("t6_valid", instr_valid_FS, 1);
    chk("t6_instr", instr_FS, EBREAK);
    step(0, 0, 32'h0, 1, 0);
    chk("t6_halt", halt_FS, HALT_EN ? 1 : 0);
    chk("t6_load", load_FS, HALT_EN ? 0 : 1);
    step(0, 0, 32'h0, 1, 0);
    chk("t6_cnt", ret_cnt_FS, HALT_EN ? 1 : 2);

    // Ack on the last allowed cycle wins, then a real timeout
    pulse_reset();
    step(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'hCAFE_0013, 0, 0);
    step(0, 0, 32'h0, 1, 0);
    chk("t4_ackwins_valid", instr_valid_FS, 1);
    chk("t4_ackwins_err", err_FS, 0);
    step(0, 0, 32'h0, 1, 0);
    reqs = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 32'h0, 0, 0);
      reqs += imem_req_FS;
    end
    step(1, 1, 32'hFFFF_FFFF, 1, 1);
    chk("t4_req_cycles", reqs, 16);
    chk("t4_err", err_FS, 1);
    chk("t4_req", imem_req_FS, 0);
    repeat (3) step(1, 1, 32'hFFFF_FFFF, 1, 1);
    chk("t4_err_sticky", err_FS, 1);
    chk("t4_req_after", imem_req_FS, 0);
    chk("t4_load_after", load_FS, 0);
    chk("t4_instr_held", instr_FS, 32'hCAFE_0013);
    chk("t4_cnt", ret_cnt_FS, 1);

    step(0, 0, 32'h0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the instruction fetch unit (IFU) and the instruction memory (imem) port.
- Per instruction it:
  - requests the instruction word from imem and latches it;
  - issues it to decode/execute;
  - waits for execute completion;
  - pulses the IFU PC load enable, with PCSrc taken from the branch decision.
- Sits between imem, the IFU (load_IF/PCSrc_IF) and the control unit. Adds an imem acknowledge watchdog and a retired-instruction counter.

Parameters:
- ACK_TIMEOUT, 16, max cycles REQ may wait for imem_ack_FS before ERROR (2..2^TW_W-1).
- TW_W, 5, watchdog counter width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk_FS  in  1  clock, rising edge.
- areset_FS  in  1  asynchronous active-high reset.
- start_FS  in  1  begin fetching; sampled only in IDLE.
- imem_req_FS  out  1  read request; held high while in REQ.
- imem_ack_FS  in  1  imem data valid this cycle.
- imem_rdata_FS  in  32  imem read data.
- instr_FS  out  32  latched instruction word.
- instr_valid_FS  out  1  one-cycle issue pulse.
- exec_done_FS  in  1  execute finished; sampled only in EXEC (tie 1 for single-cycle datapath).
- branch_taken_FS  in  1  PC source decision, valid with exec_done_FS.
- load_FS  out  1  PC load enable to IFU.
- PCSrc_FS  out  1  PC source select to IFU (0: PC+4, 1: PC+ImmExt).
- halt_FS  out  1  sticky halt flag.
- err_FS  out  1  sticky imem timeout flag.
- ret_cnt_FS  out  CNT_W  retired instruction count.

Behaviour:
- Reset: asynchronous, active-high on areset_FS.
  - state=IDLE.
  - All outputs 0; instr_FS=0, ret_cnt_FS=0, watchdog=0.
  - Asserting reset mid-operation drops imem_req_FS and load_FS immediately, without waiting for a clock edge.
- States: IDLE, REQ, ISSUE, EXEC, HALT, ERROR. 3-bit encoding, all registered.
- IDLE:
  - start_FS=1 -> REQ next cycle; watchdog cleared.
- REQ:
  - imem_req_FS=1; watchdog increments each cycle.
  - On imem_ack_FS=1: instr_FS<=imem_rdata_FS, -> ISSUE. An ack in the first REQ cycle gives zero wait.
  - No ack and watchdog==ACK_TIMEOUT-1 -> ERROR.
  - Ack and timeout in the same cycle: ack wins.
- ISSUE:
  - instr_valid_FS=1 for exactly this cycle, then -> EXEC.
  - The HALT_DETECT_EN path is described under Optional Feature.
- EXEC:
  - Waits any number of cycles for exec_done_FS.
  - load_FS=(state==EXEC)&exec_done_FS. This output is combinational so the IFU PC updates on the same edge.
  - PCSrc_FS=(state==EXEC)&exec_done_FS&branch_taken_FS. It is 0 in every other state.
  - On exec_done_FS: ret_cnt_FS increments (wraps 2^CNT_W-1 -> 0), watchdog cleared, -> REQ.
- HALT: halt_FS=1; no requests; exits only via reset.
- ERROR: err_FS=1; no requests; exits only via reset.
- start_FS outside IDLE is ignored. exec_done_FS/branch_taken_FS outside EXEC are ignored. imem_ack_FS outside REQ is ignored, and instr_FS holds.
- Best-case throughput: 3 cycles per instruction (REQ with immediate ack, ISSUE, EXEC with exec_done=1).
- Latency: start at edge N -> imem_req_FS high from edge N+1.
- instr_FS stays stable from ISSUE through EXEC.

Optional Feature:
- FETCH_HALT_DETECT_EN defined:
  - In ISSUE, if instr_FS==32'h00100073 (EBREAK), go to HALT instead of EXEC.
  - instr_valid_FS is still pulsed.
  - No load_FS pulse and no ret_cnt_FS increment for the EBREAK.
- Undefined: EBREAK is treated like any other instruction; halt_FS is constant 0.

Decomposition:
- Package fetch_seq_pkg holds:
  - state encoding constants (IDLE=0, REQ=1, ISSUE=2, EXEC=3, HALT=4, ERROR=5);
  - EBREAK_INSTR=32'h00100073;
  - default ACK_TIMEOUT/TW_W.
- Sub-module fetch_ack_watchdog: TW_W counter with clear/enable inputs and an expire output (count==ACK_TIMEOUT-1).
- FSM, instruction latch and retire counter stay in fetch_sequencer.

Test Plan:
- Reset then start=1, ack every REQ cycle, exec_done=1, branch_taken=0, 4 instructions:
  - instr_valid pulses every 3 cycles;
  - load_FS pulses 4 times with PCSrc_FS=0;
  - ret_cnt_FS=4.
- Ack delayed 5 cycles, rdata=32'h00A00093:
  - imem_req_FS high 6 cycles;
  - instr_FS=32'h00A00093 from ISSUE;
  - err_FS stays 0.
- exec_done held 0 for 7 cycles then 1 with branch_taken=1:
  - load_FS=1 and PCSrc_FS=1 only on that cycle;
  - no new imem_req_FS until the next cycle.
- No ack for 16 cycles (ACK_TIMEOUT=16):
  - ERROR; err_FS=1; imem_req_FS=0;
  - a later ack/start has no effect until reset.
- areset_FS pulsed mid-EXEC, asynchronous to the clock:
  - all outputs 0 immediately; state IDLE; ret_cnt_FS=0;
  - start again resumes normally.
- With FETCH_HALT_DETECT_EN, rdata=32'h00100073:
  - instr_valid pulse, then halt_FS=1;
  - no load_FS; ret_cnt_FS unchanged.
  - Without the macro, the same stimulus gives a normal load_FS pulse.
